// File: rtl/add_sub_pkg.sv
// Shared types and default sizing for the serial add/sub controller.
package add_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_SLICE = 4;

  // Controller phases: waiting for operands, rippling slices, presenting the result.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/slice_add_sub.sv
// Combinational SLICE-bit ripple-carry adder/subtractor; b is inverted when sub is set.
module slice_add_sub #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE-1:0] w_b;
  logic [SLICE-1:0] w_sum;
  logic             w_carry;

  assign w_b = b ^ {SLICE{sub}};

  // Ripple the carry bit by bit from the LSB.
  always_comb begin
    w_carry = cin;
    w_sum   = '0;
    for (int i = 0; i < SLICE; i++) begin
      w_sum[i] = a[i] ^ w_b[i] ^ w_carry;
      w_carry  = (a[i] & w_b[i]) | (w_carry & (a[i] ^ w_b[i]));
    end
  end

  assign sum  = w_sum;
  assign cout = w_carry;

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Serial add/sub: one shared SLICE-bit slice processes the operands LSB slice first,
// with a valid/ready request side and a valid/ready result side.
module serial_add_sub_ctrl
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             ca,
  output logic             ovf
);

  localparam int unsigned NumSlices = WIDTH / SLICE;
  localparam int unsigned IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSlices - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $fatal(1, "serial_add_sub_ctrl: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic [IdxW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_ca;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_b_msb;

  assign w_accept  = in_valid && (r_state == StIdle);
  assign w_last    = (r_idx == LastIdx);
  assign w_a_slice = r_a[r_idx*SLICE +: SLICE];
  assign w_b_slice = r_b[r_idx*SLICE +: SLICE];
  // MSB of the effective second operand (inverted for subtraction).
  assign w_b_msb   = r_b[WIDTH-1] ^ r_sub;

  slice_add_sub #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .sub  (r_sub),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StCalc;
      end
      StCalc: begin
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand capture and per-slice datapath; results only change while calculating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_ca    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= sub;
      r_idx   <= '0;
      // Carry-in of 1 completes the two's-complement negation of b.
      r_carry <= sub;
    end else if (r_state == StCalc) begin
      r_sum[r_idx*SLICE +: SLICE] <= w_slice_sum;
      r_carry                     <= w_slice_cout;
      r_idx                       <= r_idx + 1'b1;
      if (w_last) begin
        r_ca  <= w_slice_cout;
        r_ovf <= (r_a[WIDTH-1] == w_b_msb) && (w_slice_sum[SLICE-1] != r_a[WIDTH-1]);
      end
    end
  end

  assign sum = r_sum;
  assign ca  = r_ca;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Self-checking bench for serial_add_sub_ctrl: directed vectors with literal expectations
// plus an arithmetic reference model checked on every cycle a result is presented.
module tb_serial_add_sub_ctrl;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         ca;
  logic         ovf;

  int errs   = 0;
  int checks = 0;

  // Operands of the accepted operation that the model should track.
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic         m_sub;
  logic         m_live = 1'b0;

  always #5 clk = ~clk;

  serial_add_sub_ctrl #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ca        (ca),
    .ovf       (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, returns {ovf, ca, sum}.
  function automatic logic [17:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s);
    int sx, sy, r, ux, uy;
    logic c, o;
    logic [W-1:0] rs;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'({16'd0, x});
    uy = int'({16'd0, y});
    r  = s ? (sx - sy) : (sx + sy);
    o  = (r > 32767) || (r < -32768);
    c  = s ? (ux >= uy) : ((ux + uy) > 65535);
    rs = r[15:0];
    return {o, c, rs};
  endfunction

  // Every cycle a result is presented it must equal the model of the accepted operands.
  always @(negedge clk) begin
    if (!rst && m_live && out_valid) begin
      logic [17:0] e;
      e = model(m_a, m_b, m_sub);
      chk("model_sum", {16'd0, sum}, {16'd0, e[15:0]});
      chk("model_ca", {31'd0, ca}, {31'd0, e[16]});
      chk("model_ovf", {31'd0, ovf}, {31'd0, e[17]});
    end
  end

  // Issue one operation, check latency and literal result, stall hold cycles, then take it.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                       input logic [W-1:0] e_sum, input logic e_ca, input logic e_ovf,
                       input int hold, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    sub      = xs;
    m_a      = xa;
    m_b      = xb;
    m_sub    = xs;
    @(posedge clk);
    m_live = 1'b1;
    @(negedge clk);
    // Scramble inputs mid-calculation; they must be ignored.
    in_valid = 1'b0;
    a        = 16'hAAAA;
    b        = 16'hAAAA;
    sub      = ~xs;
    n        = 1;  // accept edge counted as edge 1
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 32'd5);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, e_sum});
    chk({tag, "_ca"}, {31'd0, ca}, {31'd0, e_ca});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 16'h1111 + 16'(i);
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_hold_sum"}, {16'd0, sum}, {16'd0, e_sum});
      chk({tag, "_hold_ca"}, {31'd0, ca}, {31'd0, e_ca});
      chk({tag, "_hold_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_live    = 1'b0;
    chk({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_post_sum_kept"}, {16'd0, sum}, {16'd0, e_sum});
  endtask

  initial begin
    logic [17:0] p;
    rst       = 1'b1;
    in_valid  = 1'b0;
    sub       = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_ca", {31'd0, ca}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);

    // Pin the model against hand-computed values.
    p = model(16'h8000, 16'h0001, 1'b1);
    chk("pin_model_sub", {14'd0, p}, {14'd0, 2'b11, 16'h7FFF});
    p = model(16'hFFFF, 16'h0001, 1'b0);
    chk("pin_model_add", {14'd0, p}, {14'd0, 2'b01, 16'h0000});

    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, "add_basic");
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, "sub_borrow");
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, "sub_ovf");
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "add_ripple");
    // Back-to-back after a stalled result: next accept one cycle after the handshake.
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3, "add_ovf_bp");
    do_op(16'h00FF, 16'h0F01, 1'b1, 16'hF1FE, 1'b0, 1'b0, 0, "sub_after_bp");

    // Abort during the second calculation cycle.
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h1111;
    sub      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_ca", {31'd0, ca}, 32'd0);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0, "add_after_rst");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_sub_ctrl.md
SERIAL_ADD_SUB_CTRL -- requirements
Module: serial_add_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, 16, operand/result width in bits; a multiple of SLICE.
REQ-002 SHALL have parameter SLICE, 4, width of the shared add/sub slice processed per cycle.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  request operands present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port sub  input  1  0 = a+b, 1 = a-b; sampled at accept.
REQ-009 SHALL have port a  input  WIDTH  operand A; sampled at accept.
REQ-010 SHALL have port b  input  WIDTH  operand B; sampled at accept.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port ca  output  1  final carry out; for sub, 1 = no borrow.
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 SHALL assert in_ready only in IDLE; an accept occurs on a clock edge with in_valid && in_ready.
REQ-018 SHALL, on accept, latch a, b and sub, clear the slice index, load the carry register with sub, and move IDLE->CALC.
REQ-019 SHALL, in CALC, process one SLICE-bit slice per cycle, LSB slice first: slice k = a_k + (b_k XOR {SLICE{sub}}) + carry; write to sum bits [k*SLICE +: SLICE]; register carry.
REQ-020 SHALL stay in CALC for exactly WIDTH/SLICE cycles (4 at defaults), then move CALC->DONE.
REQ-021 SHALL assert out_valid in DONE only; latency = WIDTH/SLICE+1 edges from the accept edge to out_valid high (5 at defaults).
REQ-022 SHALL set ca = carry out of the MSB slice; ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' = b XOR {WIDTH{sub}}.
REQ-023 SHALL hold sum, ca, ovf and out_valid stable in DONE until out_ready is high; DONE->IDLE on out_valid && out_ready.
REQ-024 SHALL ignore in_valid, a, b and sub outside IDLE; input changes during CALC/DONE do not affect the result.
REQ-025 SHALL NOT accept in the same cycle as a DONE handshake, because in_ready is low in DONE; the next accept is possible one cycle later.
REQ-026 SHALL make peak throughput one operation per WIDTH/SLICE+2 cycles.
REQ-027 SHALL keep sum, ca and ovf at their last values in IDLE, qualified only by out_valid.

Reset
REQ-028 SHALL, on rst high at a clock edge, go to IDLE and clear sum, ca, ovf, out_valid, carry, slice index and operand registers to 0; in_ready = 1 on the first cycle after reset.
REQ-029 SHALL abort any operation in CALC or DONE on rst, with no partial result presented.

Structure
REQ-030 SHALL keep the state enum type and default WIDTH/SLICE constants in shared package add_sub_pkg.
REQ-031 SHALL instantiate exactly one sub-module, slice_add_sub: a combinational SLICE-bit ripple-carry add/sub with inputs a, b, sub and cin, and outputs sum and cout.
REQ-032 SHALL check WIDTH % SLICE == 0 at elaboration and stop elaboration otherwise.

Verification
REQ-033 SHALL test add 0x1234+0x4321 -> sum 0x5555, ca 0, ovf 0, out_valid exactly 5 cycles after accept.
REQ-034 SHALL test sub 0x0005-0x0007 -> sum 0xFFFE, ca 0 (borrow), ovf 0; and sub 0x8000-0x0001 -> 0x7FFF, ca 1, ovf 1.
REQ-035 SHALL test add 0xFFFF+0x0001 -> 0x0000, ca 1, ovf 0 (carry ripples through all slices); and add 0x7FFF+0x0001 -> 0x8000, ca 0, ovf 1.
REQ-036 SHALL test backpressure: out_ready low 3 cycles in DONE -> sum/ca/ovf stable, in_ready 0, in_valid pulses ignored; accept 1 cycle after the handshake.
REQ-037 SHALL test rst at the 2nd CALC cycle -> next cycle state IDLE, all outputs 0, in_ready 1; a following add 0x0F0F+0x00F1 -> 0x1000.
REQ-038 SHALL test operand change during CALC (a/b driven to 0xAAAA) -> result still matches the operands latched at accept.
